// File: rtl/inv_mixcolumn_seq.sv
// Iterative AES InvMixColumns engine: COLS_PER_CYCLE columns per clock, valid/ready on
// both sides, result held on out_data until the downstream stage consumes it.
module inv_mixcolumn_seq #(
    parameter int unsigned COLS_PER_CYCLE = 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [127:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [127:0] out_data,
    output logic         busy
);

    if (COLS_PER_CYCLE != 1 && COLS_PER_CYCLE != 2 && COLS_PER_CYCLE != 4) begin : g_bad_cols
        $error("inv_mixcolumn_seq: COLS_PER_CYCLE must be 1, 2 or 4");
    end

    localparam logic [1:0] STEP = 2'(COLS_PER_CYCLE);
    localparam logic [1:0] LAST = 2'(4 - COLS_PER_CYCLE);

    typedef enum logic [1:0] {
        S_IDLE,
        S_BUSY,
        S_DONE
    } state_t;

    state_t               state_q, state_d;
    logic [1:0]           cnt_q, cnt_d;
    logic [1:0]           col_idx;
    // Element 0 sits in the MSBs, so data_q[c] is column c of the 128-bit state.
    logic [0:3][31:0]     data_q, data_d;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] s  [4];
        logic [7:0] x2 [4];
        logic [7:0] x4 [4];
        logic [7:0] x8 [4];
        logic [7:0] m9 [4];
        logic [7:0] mb [4];
        logic [7:0] md [4];
        logic [7:0] me [4];
        for (int unsigned i = 0; i < 4; i++) begin
            s[i]  = col[31 - 8*i -: 8];
            x2[i] = xtime(s[i]);
            x4[i] = xtime(x2[i]);
            x8[i] = xtime(x4[i]);
            m9[i] = x8[i] ^ s[i];
            mb[i] = x8[i] ^ x2[i] ^ s[i];
            md[i] = x8[i] ^ x4[i] ^ s[i];
            me[i] = x8[i] ^ x4[i] ^ x2[i];
        end
        return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
                m9[0] ^ me[1] ^ mb[2] ^ md[3],
                md[0] ^ m9[1] ^ me[2] ^ mb[3],
                mb[0] ^ md[1] ^ m9[2] ^ me[3]};
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        data_d    = data_q;
        col_idx   = cnt_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    data_d  = in_data;
                    cnt_d   = '0;
                    state_d = S_BUSY;
                end
            end
            S_BUSY: begin
                busy = 1'b1;
                for (int unsigned k = 0; k < COLS_PER_CYCLE; k++) begin
                    col_idx         = cnt_q + 2'(k);
                    data_d[col_idx] = inv_mix_col(data_q[col_idx]);
                end
                // STEP wraps to 0 for four columns per cycle, leaving the counter at 0.
                cnt_d = cnt_q + STEP;
                if (cnt_q == LAST) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_data = data_q;

endmodule
